// File: rtl/tx_burst_engine.sv
// Timed TX burst engine: parses {header, time, payload} packets into control/data
// FIFOs and releases samples to the DSP at the scheduled time, with underrun handling.

module tx_burst_fifo #(
  parameter int W  = 33,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wp] <= din;
  end
endmodule

module tx_burst_engine #(
  parameter int WIDTH   = 32,
  parameter int DATA_AW = 10,
  parameter int CTRL_AW = 4,
  parameter int TIME_W  = 32,
  parameter int BASE    = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [TIME_W-1:0] master_time,
  input  logic [WIDTH-1:0]  rd_dat_i,
  input  logic [3:0]        rd_flags_i,
  input  logic              rd_ready_i,
  output logic              rd_ready_o,
  output logic [WIDTH-1:0]  sample,
  output logic              run,
  input  logic              strobe,
  output logic              underrun,
  output logic              err_stb,
  output logic [1:0]        err_code,
  output logic [15:0]       err_count,
  output logic [15:0]       fifo_occupied,
  output logic              fifo_full,
  output logic              fifo_empty
);
  localparam logic [7:0] POL_ADDR = 8'(BASE);
  localparam logic [7:0] CLR_ADDR = 8'(BASE + 1);

  typedef enum logic [1:0] {P_HDR, P_TIME, P_PAY} pstate_t;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_CONT, S_UNDER, S_FLUSH} state_t;

  logic [1:0]  policy;
  logic        clear;
  logic        flush_pkt, flush_burst;
  pstate_t     pstate, pnext;
  state_t      state, nstate;
  logic [2:0]  hdr_flags;
  logic        accept;

  logic              d_push, d_pop, d_full, d_empty;
  logic [WIDTH:0]    d_head;
  logic [DATA_AW:0]  d_count;
  logic              c_push, c_pop, c_full, c_empty;
  logic [TIME_W+2:0] c_head;
  logic [CTRL_AW:0]  c_count;

  logic              c_imm, c_eob, d_eop, late;
  logic [TIME_W-1:0] c_time, tdiff;
  logic              err_set;
  logic [1:0]        err_cd;
  logic              unused_ok;

  assign unused_ok = ^{rd_flags_i[3:2], rd_flags_i[0], set_data[31:2], c_head[TIME_W+1], c_count};

  // Settings: policy register and a registered one-shot clear
  always_ff @(posedge clk) begin
    if (rst) begin
      policy <= 2'd0;
      clear  <= 1'b0;
    end else begin
      clear <= set_stb && (set_addr == CLR_ADDR);
      if (set_stb && (set_addr == POL_ADDR)) policy <= set_data[1:0];
    end
  end

  assign flush_pkt   = (policy == 2'd1);
  assign flush_burst = (policy == 2'd2);

  // Input parser
  assign rd_ready_o = !d_full && !c_full;
  assign accept     = rd_ready_i && rd_ready_o;
  assign c_push     = accept && (pstate == P_TIME);
  assign d_push     = accept && (pstate == P_PAY);

  always_comb begin
    pnext = pstate;
    if (accept) begin
      case (pstate)
        P_HDR:   pnext = P_TIME;
        P_TIME:  pnext = P_PAY;
        P_PAY:   if (rd_flags_i[1]) pnext = P_HDR;
        default: pnext = P_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pstate    <= P_HDR;
      hdr_flags <= 3'd0;
    end else begin
      pstate <= pnext;
      if (accept && (pstate == P_HDR)) hdr_flags <= rd_dat_i[2:0];
    end
  end

  tx_burst_fifo #(.W(WIDTH + 1), .AW(DATA_AW)) u_data (
    .clk(clk), .rst(rst), .clr(clear), .push(d_push), .pop(d_pop),
    .din({rd_flags_i[1], rd_dat_i}), .head(d_head), .full(d_full),
    .empty(d_empty), .count(d_count)
  );

  tx_burst_fifo #(.W(TIME_W + 3), .AW(CTRL_AW)) u_ctrl (
    .clk(clk), .rst(rst), .clr(clear), .push(c_push), .pop(c_pop),
    .din({hdr_flags, rd_dat_i[TIME_W-1:0]}), .head(c_head), .full(c_full),
    .empty(c_empty), .count(c_count)
  );

  assign c_imm  = c_head[TIME_W+2];
  assign c_eob  = c_head[TIME_W];
  assign c_time = c_head[TIME_W-1:0];
  assign d_eop  = d_head[WIDTH];
  // Wrap-aware: send time is in the past when the modular difference is negative
  assign tdiff  = c_time - master_time;
  assign late   = tdiff[TIME_W-1];

  always_comb begin
    nstate  = state;
    d_pop   = 1'b0;
    c_pop   = 1'b0;
    err_set = 1'b0;
    err_cd  = 2'd0;
    case (state)
      S_IDLE: if (!c_empty && !d_empty) nstate = S_WAIT;
      S_WAIT: begin
        if (c_imm) nstate = S_RUN;
        else if (late) begin
          nstate  = S_UNDER;
          err_set = 1'b1;
          err_cd  = 2'd2;
        end else if (master_time == c_time) nstate = S_RUN;
      end
      S_RUN: begin
        if (strobe) begin
          if (d_empty) begin
            nstate  = S_UNDER;
            err_set = 1'b1;
            err_cd  = 2'd1;
          end else begin
            d_pop = 1'b1;
            if (d_eop) begin
              c_pop  = 1'b1;
              nstate = c_eob ? S_IDLE : S_CONT;
            end
          end
        end
      end
      S_CONT: begin
        if (!c_empty) nstate = S_RUN;
        else if (strobe) begin
          nstate  = S_UNDER;
          err_set = 1'b1;
          err_cd  = 2'd1;
        end
      end
      S_UNDER: if (flush_pkt || flush_burst) nstate = S_FLUSH;
      S_FLUSH: begin
        if (!d_empty) begin
          d_pop = 1'b1;
          if (d_eop) begin
            if (c_empty) nstate = S_IDLE;
            else begin
              c_pop = 1'b1;
              if (flush_pkt || c_eob) nstate = S_IDLE;
            end
          end
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      err_stb   <= 1'b0;
      err_code  <= 2'd0;
      err_count <= 16'd0;
    end else if (clear) begin
      state     <= S_IDLE;
      err_stb   <= 1'b0;
      err_count <= 16'd0;
    end else begin
      state   <= nstate;
      err_stb <= err_set;
      if (err_set) begin
        err_code <= err_cd;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

  assign run           = (state == S_RUN) || (state == S_CONT);
  assign underrun      = (state == S_UNDER) || (state == S_FLUSH);
  assign sample        = ((state == S_RUN) && !d_empty) ? d_head[WIDTH-1:0] : '0;
  assign fifo_occupied = 16'(d_count);
  assign fifo_full     = d_full;
  assign fifo_empty    = d_empty;
endmodule
